mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the execute stage; consumes its write-back triple (wd, wreg, wdata) plus a load/store request.
- Registers the result for write-back. Performs loads and stores over a single req/ack data-memory port using a small FSM.
- Raises a stall request to pipeline control while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width
- MEMOP_W, 4, width of memory-op code

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset (`RstEnable = 1'b1)
- stall_i  in  1  hold from pipeline control; no capture when high
- ex_valid_i  in  1  execute-stage outputs valid this cycle
- ex_wd_i  in  5  destination register address
- ex_wreg_i  in  1  destination write enable
- ex_wdata_i  in  32  ALU result
- ex_memop_i  in  MEMOP_W  NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
- ex_memaddr_i  in  ADDR_W  effective address
- ex_memdata_i  in  32  store data
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = store
- mem_addr_o  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
- mem_sel_o  out  4  byte-lane enables
- mem_wdata_o  out  32  store data, replicated into lanes
- mem_rdata_i  in  32  read data, valid with ack
- mem_ack_i  in  1  transaction complete
- stallreq_o  out  1  upstream must hold its outputs
- wb_valid_o  out  1  write-back outputs valid
- wb_wd_o  out  5  write-back register address
- wb_wreg_o  out  1  write-back enable
- wb_wdata_o  out  32  write-back data

Behaviour:
- Reset:
  - FSM enters IDLE.
  - All outputs are 0.
  - Reset mid-transaction abandons it. mem_req_o is 0 the cycle after the reset edge. A late ack in IDLE is ignored.
- FSM states:
  - IDLE: capture enabled.
  - BUSY: request outstanding.
- IDLE, ex_valid_i=1, stall_i=0, memop=NONE:
  - Outputs register at the edge: wb_wd_o=ex_wd_i, wb_wreg_o=ex_wreg_i, wb_wdata_o=ex_wdata_i, wb_valid_o=1.
  - Latency is 1 cycle.
- IDLE, ex_valid_i=1, stall_i=0, load/store:
  - Latch wd/wreg/op/addr/data. Go to BUSY.
  - Drive mem_req_o=1, mem_we_o, mem_addr_o, mem_sel_o and mem_wdata_o from the next cycle.
  - wb_valid_o=0 (bubble).
- IDLE with stall_i=1 or ex_valid_i=0:
  - No capture. wb_valid_o=0. Other wb outputs hold.
- BUSY:
  - stallreq_o=1, combinational from state.
  - ex_* and stall_i are ignored.
  - Request outputs are stable until ack.
- BUSY with mem_ack_i=1 at the edge:
  - Go to IDLE. mem_req_o=0 next cycle.
  - wb outputs load the result; wb_valid_o=1.
  - Store: wb_wreg_o=0.
  - Ack in the first request cycle is legal. Minimum memory-op latency is 2 cycles from capture to wb_valid_o.
- Lanes, little-endian, off = addr[1:0]:
  - byte ops: sel = 4'b0001<<off
  - halfword ops: sel = 4'b0011<<{off[1],1'b0}
  - word ops: sel = 4'b1111
  - Store data: SB replicates byte ×4; SH replicates half ×2.
- Load extension:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend.
  - LW passes through.
- wb_wreg_o is forced 0 whenever wb_wd_o==0 (x0 never written).
- Illegal memop encoding is treated as NONE.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Adds output port misalign_o (1 bit).
  - Misaligned access (H ops with addr[0]=1; W ops with addr[1:0]!=0) issues no request and stays IDLE.
  - Next cycle: wb_valid_o=1, wb_wreg_o=0, misalign_o=1 for exactly one cycle.
- Undefined:
  - No port.
  - Offending low address bits are treated as 0 (H ops ignore addr[0], W ops ignore addr[1:0]).
  - Access proceeds normally.

Decomposition:
- Shared defs include holds:
  - memop encodings (EXE_LB_OP…EXE_SW_OP, EXE_NOP_MEM)
  - MemOpBus
  - RegBus, RegAddrBus
  - ZeroWord, RstEnable
  - FSM state encodings
- Sub-module mem_align (combinational):
  - Inputs: op and addr.
  - Outputs: sel, replicated store data, extended load data, misaligned flag.
- FSM and registers stay in mem_stage.

Test Plan:
- ALU pass: memop=NONE, wd=5, wreg=1, wdata=32'h1234 → next cycle wb_valid_o=1, wb_wd_o=5, wb_wdata_o=32'h1234, stallreq_o=0.
- LB: addr=32'h103, rdata=32'h80FF_0000, ack in 3rd request cycle:
  - During request: mem_addr_o=32'h100, mem_sel_o=4'b1000, stallreq_o=1 for 3 cycles.
  - Result: wb_wdata_o=32'hFFFF_FF80.
- LHU / SH:
  - LHU: addr=32'h102, rdata=32'hBEEF_0000 → wb_wdata_o=32'h0000_BEEF.
  - SH: data=32'hxxxx_ABCD at 32'h102 → mem_sel_o=4'b1100, mem_wdata_o=32'hABCD_ABCD, mem_we_o=1, wb_wreg_o=0.
- x0: NONE op, wd=0, wreg=1 → wb_wreg_o=0.
- Reset mid-transaction: rst=1 while BUSY, before ack → next cycle mem_req_o=0, stallreq_o=0, all outputs 0; a subsequent ack is ignored.
- LW at 32'h102:
  - With MEM_MISALIGN_TRAP_EN: no mem_req_o; misalign_o=1 one cycle with wb_valid_o=1, wb_wreg_o=0.
  - Without: mem_addr_o=32'h100, sel=4'b1111.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, memory-op encodings,
// FSM states and small op-classification helpers.
package mem_stage_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int MemOpBus   = 4;

   localparam logic              RstEnable = 1'b1;
   localparam logic [RegBus-1:0] ZeroWord  = 32'h0000_0000;

   typedef enum logic [MemOpBus-1:0] {
      EXE_NOP_MEM = 4'd0,
      EXE_LB_OP   = 4'd1,
      EXE_LH_OP   = 4'd2,
      EXE_LW_OP   = 4'd3,
      EXE_LBU_OP  = 4'd4,
      EXE_LHU_OP  = 4'd5,
      EXE_SB_OP   = 4'd6,
      EXE_SH_OP   = 4'd7,
      EXE_SW_OP   = 4'd8
   } memop_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   // Any code outside the defined set collapses to NONE.
   function automatic memop_e decode_memop(input logic [31:0] code);
      memop_e op;
      if (code > 32'd8)
         op = EXE_NOP_MEM;
      else
         op = memop_e'(code[3:0]);
      return op;
   endfunction

   function automatic logic is_store(input memop_e op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the MEM stage: lane selects, store replication and
// load extension. MEM_MISALIGN_TRAP_EN adds the misaligned flag output.
module mem_align
   import mem_stage_pkg::*;
(
   input  memop_e            op,
   input  logic [1:0]        addr,
   input  logic [RegBus-1:0] store_data,
   input  logic [RegBus-1:0] load_data,
   output logic [3:0]        sel,
   output logic [RegBus-1:0] wdata,
   output logic [RegBus-1:0] rdata
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misaligned
`endif
);

   logic [RegBus-1:0] byte_shift;
   logic [RegBus-1:0] half_shift;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;

   // Halfword ops only honour addr[1]; the low bit never moves the lane.
   assign byte_shift = load_data >> {addr, 3'b000};
   assign half_shift = load_data >> {addr[1], 4'b0000};
   assign byte_lane  = byte_shift[7:0];
   assign half_lane  = half_shift[15:0];

   always_comb begin
      sel   = 4'b0000;
      wdata = ZeroWord;
      rdata = ZeroWord;
      case (op)
         EXE_LB_OP: begin
            sel   = 4'b0001 << addr;
            rdata = {{24{byte_lane[7]}}, byte_lane};
         end
         EXE_LBU_OP: begin
            sel   = 4'b0001 << addr;
            rdata = {24'h0, byte_lane};
         end
         EXE_LH_OP: begin
            sel   = 4'b0011 << {addr[1], 1'b0};
            rdata = {{16{half_lane[15]}}, half_lane};
         end
         EXE_LHU_OP: begin
            sel   = 4'b0011 << {addr[1], 1'b0};
            rdata = {16'h0, half_lane};
         end
         EXE_LW_OP: begin
            sel   = 4'b1111;
            rdata = load_data;
         end
         EXE_SB_OP: begin
            sel   = 4'b0001 << addr;
            wdata = {4{store_data[7:0]}};
         end
         EXE_SH_OP: begin
            sel   = 4'b0011 << {addr[1], 1'b0};
            wdata = {2{store_data[15:0]}};
         end
         EXE_SW_OP: begin
            sel   = 4'b1111;
            wdata = store_data;
         end
         default: begin
            sel   = 4'b0000;
            wdata = ZeroWord;
            rdata = ZeroWord;
         end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = addr[0];
         EXE_LW_OP, EXE_SW_OP:             misaligned = |addr;
         default:                          misaligned = 1'b0;
      endcase
   end
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers ALU results for write-back and runs loads and
// stores over a req/ack port. MEM_MISALIGN_TRAP_EN adds misalign_o.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int MEMOP_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  ex_valid_i,
   input  logic [RegAddrBus-1:0] ex_wd_i,
   input  logic                  ex_wreg_i,
   input  logic [RegBus-1:0]     ex_wdata_i,
   input  logic [MEMOP_W-1:0]    ex_memop_i,
   input  logic [ADDR_W-1:0]     ex_memaddr_i,
   input  logic [RegBus-1:0]     ex_memdata_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [3:0]            mem_sel_o,
   output logic [RegBus-1:0]     mem_wdata_o,
   input  logic [RegBus-1:0]     mem_rdata_i,
   input  logic                  mem_ack_i,
   output logic                  stallreq_o,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic                  misalign_o,
`endif
   output logic                  wb_valid_o,
   output logic [RegAddrBus-1:0] wb_wd_o,
   output logic                  wb_wreg_o,
   output logic [RegBus-1:0]     wb_wdata_o
);

   state_e                state_reg;
   memop_e                op_reg;
   logic [1:0]            off_reg;
   logic [RegAddrBus-1:0] wd_reg;
   logic                  wreg_reg;

   logic                  mem_req_reg;
   logic                  mem_we_reg;
   logic [ADDR_W-1:0]     mem_addr_reg;
   logic [3:0]            mem_sel_reg;
   logic [RegBus-1:0]     mem_wdata_reg;

   logic                  wb_valid_reg;
   logic [RegAddrBus-1:0] wb_wd_reg;
   logic                  wb_wreg_reg;
   logic [RegBus-1:0]     wb_wdata_reg;

   memop_e                ex_op;
   memop_e                align_op;
   logic [1:0]            align_off;
   logic [3:0]            align_sel;
   logic [RegBus-1:0]     align_wdata;
   logic [RegBus-1:0]     align_rdata;

   assign ex_op = decode_memop(32'(ex_memop_i));

   // One aligner serves both phases: the incoming op while IDLE (request
   // setup), the latched op while BUSY (load extension at ack).
   assign align_op  = (state_reg == S_BUSY) ? op_reg  : ex_op;
   assign align_off = (state_reg == S_BUSY) ? off_reg : ex_memaddr_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   logic align_misaligned;
   logic misalign_reg;
`endif

   mem_align u_align (
      .op         (align_op),
      .addr       (align_off),
      .store_data (ex_memdata_i),
      .load_data  (mem_rdata_i),
      .sel        (align_sel),
      .wdata      (align_wdata),
      .rdata      (align_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misaligned (align_misaligned)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_reg     <= S_IDLE;
         op_reg        <= EXE_NOP_MEM;
         off_reg       <= 2'b00;
         wd_reg        <= '0;
         wreg_reg      <= 1'b0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_sel_reg   <= 4'b0000;
         mem_wdata_reg <= ZeroWord;
         wb_valid_reg  <= 1'b0;
         wb_wd_reg     <= '0;
         wb_wreg_reg   <= 1'b0;
         wb_wdata_reg  <= ZeroWord;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_reg  <= 1'b0;
`endif
      end else begin
         wb_valid_reg <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_reg <= 1'b0;
`endif
         case (state_reg)
            S_IDLE: begin
               if (ex_valid_i && !stall_i) begin
                  if (ex_op == EXE_NOP_MEM) begin
                     wb_valid_reg <= 1'b1;
                     wb_wd_reg    <= ex_wd_i;
                     wb_wreg_reg  <= ex_wreg_i && (ex_wd_i != '0);
                     wb_wdata_reg <= ex_wdata_i;
                  end
`ifdef MEM_MISALIGN_TRAP_EN
                  else if (align_misaligned) begin
                     wb_valid_reg <= 1'b1;
                     wb_wd_reg    <= ex_wd_i;
                     wb_wreg_reg  <= 1'b0;
                     wb_wdata_reg <= ZeroWord;
                     misalign_reg <= 1'b1;
                  end
`endif
                  else begin
                     op_reg        <= ex_op;
                     off_reg       <= ex_memaddr_i[1:0];
                     wd_reg        <= ex_wd_i;
                     wreg_reg      <= ex_wreg_i;
                     mem_req_reg   <= 1'b1;
                     mem_we_reg    <= is_store(ex_op);
                     mem_addr_reg  <= {ex_memaddr_i[ADDR_W-1:2], 2'b00};
                     mem_sel_reg   <= align_sel;
                     mem_wdata_reg <= align_wdata;
                     state_reg     <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (mem_ack_i) begin
                  mem_req_reg  <= 1'b0;
                  state_reg    <= S_IDLE;
                  wb_valid_reg <= 1'b1;
                  wb_wd_reg    <= wd_reg;
                  wb_wreg_reg  <= !is_store(op_reg) && wreg_reg && (wd_reg != '0);
                  wb_wdata_reg <= is_store(op_reg) ? ZeroWord : align_rdata;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign stallreq_o  = (state_reg == S_BUSY);
   assign mem_req_o   = mem_req_reg;
   assign mem_we_o    = mem_we_reg;
   assign mem_addr_o  = mem_addr_reg;
   assign mem_sel_o   = mem_sel_reg;
   assign mem_wdata_o = mem_wdata_reg;
   assign wb_valid_o  = wb_valid_reg;
   assign wb_wd_o     = wb_wd_reg;
   assign wb_wreg_o   = wb_wreg_reg;
   assign wb_wdata_o  = wb_wdata_reg;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_o  = misalign_reg;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: expected write-backs are queued at
// stimulus time and retired by a negedge monitor, request-side checks inline.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        ex_valid_i = 1'b0;
   logic [4:0]  ex_wd_i = '0;
   logic        ex_wreg_i = 1'b0;
   logic [31:0] ex_wdata_i = '0;
   logic [3:0]  ex_memop_i = '0;
   logic [31:0] ex_memaddr_i = '0;
   logic [31:0] ex_memdata_i = '0;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;
   logic        stallreq_o;
   logic        wb_valid_o;
   logic [4:0]  wb_wd_o;
   logic        wb_wreg_o;
   logic [31:0] wb_wdata_o;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        chk_data;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   mem_stage #(.ADDR_W(32), .MEMOP_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .ex_valid_i   (ex_valid_i),
      .ex_wd_i      (ex_wd_i),
      .ex_wreg_i    (ex_wreg_i),
      .ex_wdata_i   (ex_wdata_i),
      .ex_memop_i   (ex_memop_i),
      .ex_memaddr_i (ex_memaddr_i),
      .ex_memdata_i (ex_memdata_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_sel_o    (mem_sel_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i),
      .stallreq_o   (stallreq_o),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign_o   (misalign_o),
`endif
      .wb_valid_o   (wb_valid_o),
      .wb_wd_o      (wb_wd_o),
      .wb_wreg_o    (wb_wreg_o),
      .wb_wdata_o   (wb_wdata_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Retire write-backs against the scoreboard, including their cycle.
   always @(negedge clk) begin
      if (!rst && wb_valid_o) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected cyc=%0d wd=%0d wreg=%0b wdata=%h", cyc, wb_wd_o, wb_wreg_o, wb_wdata_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (wb_wd_o !== e.wd || wb_wreg_o !== e.wreg || cyc != e.cyc ||
                (e.chk_data && wb_wdata_o !== e.wdata)) begin
               failures++;
               $display("FAIL wb_result got wd=%0d wreg=%0b wdata=%h cyc=%0d want wd=%0d wreg=%0b wdata=%h cyc=%0d",
                        wb_wd_o, wb_wreg_o, wb_wdata_o, cyc, e.wd, e.wreg, e.wdata, e.cyc);
            end
         end
      end
   end

   task automatic push_exp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata, input logic chk);
      exp_t e;
      e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = chk; e.cyc = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic drive_ex(input memop_e op, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] data);
      ex_valid_i = 1'b1; ex_memop_i = op; ex_wd_i = wd; ex_wreg_i = wreg;
      ex_wdata_i = wdata; ex_memaddr_i = addr; ex_memdata_i = data;
   endtask

   task automatic idle_ex();
      ex_valid_i = 1'b0; ex_memop_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, stallreq_o,
           wb_valid_o, wb_wd_o, wb_wreg_o, wb_wdata_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got req=%0b addr=%h sel=%b wb_valid=%0b wd=%0d wdata=%h want all 0",
                  mem_req_o, mem_addr_o, mem_sel_o, wb_valid_o, wb_wd_o, wb_wdata_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata, input logic [3:0] code);
      @(negedge clk);
      drive_ex(memop_e'(4'd0), wd, wreg, wdata, 32'h0, 32'h0);
      ex_memop_i = code;
      push_exp(wd, wreg && (wd != 0), wdata, 1'b1);
      @(negedge clk);
      idle_ex();
      checks++;
      if (stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
         failures++;
         $display("FAIL alu_no_request got stallreq=%0b req=%0b want 0 0", stallreq_o, mem_req_o);
      end
   endtask

   // Memory op with ack in request cycle ack_at; ex and stall are toggled
   // during BUSY to show they are ignored.
   task automatic test_memop(input string name, input memop_e op, input logic [4:0] wd,
                             input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                             input int ack_at, input logic [31:0] e_addr, input logic [3:0] e_sel,
                             input logic [31:0] e_wdata, input logic [31:0] e_result);
      logic st;
      st = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
      @(negedge clk);
      drive_ex(op, wd, 1'b1, 32'hDEAD_0000, addr, data);
      @(negedge clk);
      drive_ex(EXE_NOP_MEM, 5'd9, 1'b1, 32'h5555_5555, 32'h0, 32'h0);
      stall_i = 1'b1;
      for (int i = 1; i <= ack_at; i++) begin
         checks++;
         if (mem_req_o !== 1'b1 || stallreq_o !== 1'b1 || mem_addr_o !== e_addr || mem_sel_o !== e_sel ||
             mem_we_o !== st || (st && mem_wdata_o !== e_wdata) || wb_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_request cycle=%0d got req=%0b stall=%0b we=%0b addr=%h sel=%b wdata=%h want req=1 stall=1 we=%0b addr=%h sel=%b wdata=%h",
                     name, i, mem_req_o, stallreq_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, st, e_addr, e_sel, e_wdata);
         end
         if (i == ack_at) begin
            mem_ack_i = 1'b1;
            mem_rdata_i = rdata;
            push_exp(wd, !st && (wd != 0), e_result, !st);
            idle_ex();
            stall_i = 1'b0;
         end
         @(negedge clk);
      end
      mem_ack_i = 1'b0;
      mem_rdata_i = 32'h0;
      checks++;
      if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
         failures++;
         $display("FAIL %s_release got req=%0b stall=%0b want 0 0", name, mem_req_o, stallreq_o);
      end
   endtask

   task automatic test_stall();
      logic [4:0] held;
      @(negedge clk);
      held = wb_wd_o;
      drive_ex(EXE_NOP_MEM, 5'd7, 1'b1, 32'h7777_7777, 32'h0, 32'h0);
      stall_i = 1'b1;
      @(negedge clk);
      checks++;
      if (wb_valid_o !== 1'b0 || wb_wd_o !== held) begin
         failures++;
         $display("FAIL stall_hold got valid=%0b wd=%0d want valid=0 wd=%0d", wb_valid_o, wb_wd_o, held);
      end
      stall_i = 1'b0;
      idle_ex();
      @(negedge clk);
      checks++;
      if (wb_valid_o !== 1'b0 || wb_wd_o !== held) begin
         failures++;
         $display("FAIL invalid_hold got valid=%0b wd=%0d want valid=0 wd=%0d", wb_valid_o, wb_wd_o, held);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive_ex(EXE_NOP_MEM, 5'(10 + i), 1'b1, 32'hA000_0000 + 32'(i), 32'h0, 32'h0);
         push_exp(5'(10 + i), 1'b1, 32'hA000_0000 + 32'(i), 1'b1);
         @(negedge clk);
      end
      idle_ex();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive_ex(EXE_LW_OP, 5'd3, 1'b1, 32'h0, 32'h0000_0200, 32'h0);
      @(negedge clk);
      idle_ex();
      checks++;
      if (mem_req_o !== 1'b1 || stallreq_o !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_busy got req=%0b stall=%0b want 1 1", mem_req_o, stallreq_o);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, stallreq_o,
           wb_valid_o, wb_wd_o, wb_wreg_o, wb_wdata_o} !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs got req=%0b stall=%0b addr=%h sel=%b wd=%0d wdata=%h want all 0",
                  mem_req_o, stallreq_o, mem_addr_o, mem_sel_o, wb_wd_o, wb_wdata_o);
      end
      rst = 1'b0;
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ack_i = 1'b0;
      checks++;
      if (wb_valid_o !== 1'b0 || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
         failures++;
         $display("FAIL late_ack got valid=%0b req=%0b stall=%0b want 0 0 0", wb_valid_o, mem_req_o, stallreq_o);
      end
   endtask

   task automatic test_lw_misaligned();
`ifdef MEM_MISALIGN_TRAP_EN
      @(negedge clk);
      drive_ex(EXE_LW_OP, 5'd6, 1'b1, 32'h0, 32'h0000_0102, 32'h0);
      push_exp(5'd6, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      idle_ex();
      checks++;
      if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0 || misalign_o !== 1'b1) begin
         failures++;
         $display("FAIL misalign_trap got req=%0b stall=%0b misalign=%0b want 0 0 1", mem_req_o, stallreq_o, misalign_o);
      end
      @(negedge clk);
      checks++;
      if (misalign_o !== 1'b0) begin
         failures++;
         $display("FAIL misalign_pulse got %0b want 0", misalign_o);
      end
`else
      test_memop("lw_unaligned", EXE_LW_OP, 5'd6, 32'h0000_0102, 32'h0, 32'h1357_9BDF, 1,
                 32'h0000_0100, 4'b1111, 32'h0, 32'h1357_9BDF);
`endif
   endtask

   initial begin
      test_reset();
      test_alu(5'd5, 1'b1, 32'h0000_1234, 4'd0);
      test_alu(5'd0, 1'b1, 32'hCAFE_F00D, 4'd0);           // x0 never written
      test_alu(5'd17, 1'b0, 32'h0BAD_BEEF, 4'd0);
      test_alu(5'd21, 1'b1, 32'h2121_2121, 4'hF);          // illegal op acts as NONE
      test_memop("lb", EXE_LB_OP, 5'd8, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3,
                 32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
      test_memop("lhu", EXE_LHU_OP, 5'd9, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 1,
                 32'h0000_0100, 4'b1100, 32'h0, 32'h0000_BEEF);
      test_memop("lh", EXE_LH_OP, 5'd10, 32'h0000_0200, 32'h0, 32'h1234_8001, 2,
                 32'h0000_0200, 4'b0011, 32'h0, 32'hFFFF_8001);
      test_memop("lbu", EXE_LBU_OP, 5'd11, 32'h0000_0301, 32'h0, 32'h0000_F100, 1,
                 32'h0000_0300, 4'b0010, 32'h0, 32'h0000_00F1);
      test_memop("sh", EXE_SH_OP, 5'd12, 32'h0000_0102, 32'h7777_ABCD, 32'h0, 2,
                 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0);
      test_memop("sb", EXE_SB_OP, 5'd13, 32'h0000_0101, 32'h1234_565A, 32'h0, 1,
                 32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 32'h0);
      test_memop("sw", EXE_SW_OP, 5'd14, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0, 1,
                 32'h0000_0404, 4'b1111, 32'hDEAD_BEEF, 32'h0);
      test_memop("lw_x0", EXE_LW_OP, 5'd0, 32'h0000_0500, 32'h0, 32'h1111_2222, 1,
                 32'h0000_0500, 4'b1111, 32'h0, 32'h1111_2222);
      test_stall();
      test_back_to_back();
      test_lw_misaligned();
      test_reset_mid();
      test_alu(5'd30, 1'b1, 32'h3030_3030, 4'd0);
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
